// File: rtl/program_loader.sv
// program_loader: streams bytes into instruction memory as little-endian words.
// Holds the CPU in reset while loading and verifies a trailing XOR checksum.
module program_loader #(
    parameter  int WORD_SIZE = 32,
    parameter  int MEM_DEPTH = 32,
    localparam int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [WORD_SIZE-1:0] imem_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t               state;
    logic [1:0]           byte_idx;
    logic [ADDR_W-1:0]    word_idx;
    logic [7:0]           n_words;
    logic [WORD_SIZE-1:0] asm_q;
    logic [WORD_SIZE-1:0] csum;
    logic [WORD_SIZE-1:0] word;
    logic                 accept;
    logic                 last_byte;
    logic                 last_word;
    logic                 bad_count;

    assign in_ready  = (state == COUNT) || (state == DATA) || (state == CHECK);
    assign accept    = in_valid && in_ready;
    // New byte enters at the top so byte 0 ends up in bits [7:0].
    assign word      = {in_data, asm_q[WORD_SIZE-1:8]};
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (8'(word_idx) + 8'd1 == n_words);
    assign bad_count = (in_data == 8'd0) || (in_data > 8'(MEM_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_idx   <= '0;
            word_idx   <= '0;
            n_words    <= '0;
            asm_q      <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                asm_q <= word;
            end
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (load_start) begin
                        state    <= COUNT;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (bad_count) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            n_words  <= in_data;
                            word_idx <= '0;
                            byte_idx <= '0;
                            csum     <= '0;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= word;
                            csum       <= csum ^ word;
                            word_idx   <= word_idx + ADDR_W'(1);
                            if (last_word) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            if (word == csum) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state <= ERR;
                                error <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader.
// Expected writes are queued by the driver and popped by a write monitor.
module tb_program_loader;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int          compared   = 0;
    int          mismatched = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] words[$];

    program_loader #(.WORD_SIZE(32), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .load_start(load_start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr %0d data %h expected none",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), mon_e.addr);
                chk("write_data", imem_wdata, mon_e.data);
            end
        end
    end

    task automatic idle(input int g);
        for (int i = 0; i < g; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    function automatic logic [31:0] fold_xor();
        logic [31:0] s;
        s = '0;
        foreach (words[i]) s ^= words[i];
        return s;
    endfunction

    task automatic check_status(input string tag, input bit ok);
        idle(3);
        chk({tag, "_done"}, 32'(done), 32'(ok));
        chk({tag, "_error"}, 32'(error), 32'(!ok));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!ok));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Sends count byte n, the words (only if n is legal) and checksum cs.
    task automatic run_load(input string tag, input int n, input logic [31:0] cs,
                            input int gap_max, input bit mid_start);
        logic [31:0] w;
        bit          n_ok;
        n_ok = (n >= 1) && (n <= MEM_DEPTH);
        pulse_start();
        send_byte(8'(n));
        if (n_ok) begin
            foreach (words[i]) begin
                w = words[i];
                for (int k = 0; k < 4; k++) begin
                    if (gap_max > 0) idle($urandom_range(1, gap_max));
                    if (mid_start && i == 0 && k == 2) pulse_start();
                    if (k == 3) exp_q.push_back('{addr: i, data: w});
                    send_byte(w[8*k +: 8]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (gap_max > 0) idle($urandom_range(1, gap_max));
                send_byte(cs[8*k +: 8]);
            end
        end
        check_status(tag, n_ok && (cs == fold_xor()));
    endtask

    task automatic good_words();
        words = {32'hE3A01005, 32'h12345678};
    endtask

    initial begin
        int          n;
        logic [31:0] cs;
        rst        = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_cpu_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        rst = 1'b1;
        @(negedge clk);

        // Valid bytes while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        idle(2);

        good_words();
        run_load("good", 2, 32'hF194467D, 0, 1'b0);
        run_load("bad_sum", 2, 32'h00000000, 0, 1'b0);
        words = {};
        run_load("count0", 0, 32'h0, 0, 1'b0);
        run_load("count33", 33, 32'h0, 0, 1'b0);
        good_words();
        run_load("after_err", 2, 32'hF194467D, 0, 1'b0);
        run_load("backpress", 2, 32'hF194467D, 3, 1'b1);

        // Reset in the middle of the data phase.
        pulse_start();
        send_byte(8'd2);
        exp_q.push_back('{addr: 0, data: 32'hE3A01005});
        foreach (words[i]) begin
            if (i == 0) begin
                for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8]);
            end
        end
        send_byte(8'h78);
        send_byte(8'h56);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 0);
        chk("midrst_imem_we", 32'(imem_we), 0);
        chk("midrst_imem_addr", 32'(imem_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        chk("midrst_pending", exp_q.size(), 0);
        run_load("reload", 2, 32'hF194467D, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 10);
            if (r == 5) n = MEM_DEPTH;
            if (r == 6) n = $urandom_range(MEM_DEPTH + 1, 255);
            words = {};
            if (n <= MEM_DEPTH) begin
                for (int i = 0; i < n; i++) words.push_back($urandom);
            end
            cs = fold_xor();
            if ($urandom_range(0, 2) == 0) cs ^= 32'(1) << $urandom_range(0, 31);
            run_load($sformatf("rand%0d", r), n, cs, $urandom_range(0, 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
